// File: rtl/slice_lane_collector_if.sv
// Handshake bundle between the parity-slice producer, the slice_lane_collector
// and the lane-oriented consumer. The producer/consumer pair drives the master
// side; the collector takes the slave side.
interface slice_lane_collector_if #(
  parameter int SLICES = 64,
  parameter int LANES  = 25
);

  // slice input side
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES-1:0]           in_slice;
  logic                       in_last;

  // lane output side
  logic                       out_valid;
  logic                       out_ready;
  logic [SLICES-1:0]          out_lane;
  logic [$clog2(LANES)-1:0]   out_lane_index;
  logic                       out_last;

  // status
  logic                       done;
  logic                       frame_err;

  modport master (
    output in_valid, in_slice, in_last, out_ready,
    input  in_ready, out_valid, out_lane, out_lane_index, out_last, done, frame_err
  );

  modport slave (
    input  in_valid, in_slice, in_last, out_ready,
    output in_ready, out_valid, out_lane, out_lane_index, out_last, done, frame_err
  );

endinterface

// File: rtl/slice_lane_collector.sv
// slice_lane_collector: collects SLICES slices of 25 bits each (one per z),
// holds the full state in a single buffer, then emits it transposed as 25
// lanes of SLICES bits. Fill and drain never overlap; frame boundaries are
// purely count based and in_last is only used to flag framing errors.
module slice_lane_collector #(
  parameter int SLICES = 64,
  parameter int LANES  = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  slice_lane_collector_if.slave bus
);

  localparam int SW = $clog2(SLICES);
  localparam int LW = $clog2(LANES);
  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    slice_cnt_q, slice_cnt_d;
  logic [LW-1:0]    lane_cnt_q, lane_cnt_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
  logic [LANES-1:0] mem_q [SLICES];

  logic             in_ready_s;
  logic             out_valid_s;
  logic             in_hs_s;
  logic             out_hs_s;
  logic             wr_en_s;
  logic             last_slice_s;
  logic             last_lane_s;
  logic [SLICES-1:0] lane_s;

  // Handshake qualifiers: both decode state only, so ready/valid never depend
  // on the partner's valid/ready. Reset forces both low in the reset cycle.
  always_comb begin
    in_ready_s   = 1'b0;
    out_valid_s  = 1'b0;
    if (rst) begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      in_ready_s  = (state_q == FILL);
      out_valid_s = (state_q == DRAIN);
    end
    in_hs_s      = bus.in_valid & in_ready_s;
    out_hs_s     = out_valid_s & bus.out_ready;
    last_slice_s = (slice_cnt_q == LAST_SLICE);
    last_lane_s  = (lane_cnt_q == LAST_LANE);
  end

  // Next-state logic: slice counting in FILL, lane stepping in DRAIN,
  // sticky framing check on every accepted slice.
  always_comb begin
    state_d     = state_q;
    slice_cnt_d = slice_cnt_q;
    lane_cnt_d  = lane_cnt_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
    wr_en_s     = 1'b0;
    case (state_q)
      FILL: begin
        if (in_hs_s) begin
          wr_en_s = 1'b1;
          if (last_slice_s) begin
            slice_cnt_d = {SW{1'b0}};
            state_d     = DRAIN;
          end else begin
            slice_cnt_d = slice_cnt_q + SW'(1);
            state_d     = FILL;
          end
          // in_last must coincide exactly with the count-based final slice
          if (bus.in_last != last_slice_s) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = frame_err_q;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      DRAIN: begin
        if (out_hs_s) begin
          if (last_lane_s) begin
            lane_cnt_d = {LW{1'b0}};
            done_d     = 1'b1;
            state_d    = FILL;
          end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
            state_d    = DRAIN;
          end
        end else begin
          lane_cnt_d = lane_cnt_q;
        end
      end
      default: begin
        state_d     = FILL;
        slice_cnt_d = {SW{1'b0}};
        lane_cnt_d  = {LW{1'b0}};
      end
    endcase
  end

  // State, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      slice_cnt_q <= {SW{1'b0}};
      lane_cnt_q  <= {LW{1'b0}};
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_cnt_q <= slice_cnt_d;
      lane_cnt_q  <= lane_cnt_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Slice buffer: one row per z, written only while filling.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int z = 0; z < SLICES; z++) begin
        mem_q[z] <= {LANES{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[slice_cnt_q] <= bus.in_slice;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Transpose: lane bit z is bit lane_cnt of row z.
  always_comb begin
    lane_s = {SLICES{1'b0}};
    for (int z = 0; z < SLICES; z++) begin
      lane_s[z] = mem_q[z][lane_cnt_q];
    end
  end

  // Output mapping; the lane bus reads zero whenever it is not valid.
  always_comb begin
    bus.in_ready       = in_ready_s;
    bus.out_valid      = out_valid_s;
    bus.out_lane       = {SLICES{1'b0}};
    if (out_valid_s) begin
      bus.out_lane = lane_s;
    end else begin
      bus.out_lane = {SLICES{1'b0}};
    end
    bus.out_lane_index = lane_cnt_q;
    bus.out_last       = out_valid_s & last_lane_s;
    bus.done           = done_q;
    bus.frame_err      = frame_err_q;
  end

endmodule

// File: tb/tb_slice_lane_collector.sv
// Scoreboard bench for slice_lane_collector: a reference model watches the
// accepted slices, transposes whole frames with plain loops and queues the
// expected lanes; a monitor pops and compares on every lane handshake.
module tb_slice_lane_collector;

  localparam int SL = 64;
  localparam int LN = 25;

  typedef struct {
    logic [SL-1:0] lane;
    int            idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slice_lane_collector_if #(.SLICES(SL), .LANES(LN)) ifc ();

  slice_lane_collector #(.SLICES(SL), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  exp_t          exp_q[$];
  logic [LN-1:0] m_buf [SL];
  bit            m_fill  = 1'b1;
  int            m_cnt   = 0;
  int            m_lane  = 0;
  bit            m_err   = 1'b0;
  bit            m_done  = 1'b0;
  bit            chk_en  = 1'b0;
  int            cyc     = 0;
  int            m_t0    = 0;
  bit            tp_chk  = 1'b0;
  int            b2b_hits = 0;
  int            out_mode = 3;   // 0 always ready, 1 toggle, 2 random, 3 manual

  // stimulus frame
  logic [LN-1:0] frame_data [SL];
  logic          frame_last [SL];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + model: compares at the falling edge, then advances the model by
  // the handshakes that the next rising edge will complete.
  initial begin : monitor
    exp_t e;
    bit            stall_prev = 1'b0;
    logic [SL-1:0] prev_lane;
    int            prev_idx;
    logic          prev_last;
    bit            done_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        check_bit("in_ready", ifc.in_ready, !rst && m_fill);
        check_bit("out_valid", ifc.out_valid, !rst && !m_fill);
        check_bit("done", ifc.done, m_done);
        check_bit("frame_err", ifc.frame_err, m_err);
        if (stall_prev) begin
          check_vec("stall_lane", ifc.out_lane, prev_lane);
          check_int("stall_index", int'(ifc.out_lane_index), prev_idx);
          check_bit("stall_last", ifc.out_last, prev_last);
        end
        if (ifc.out_valid && ifc.out_ready) begin
          if (exp_q.size() == 0) begin
            check_int("unexpected_lane", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_vec("lane_data", ifc.out_lane, e.lane);
            check_int("lane_index", int'(ifc.out_lane_index), e.idx);
            check_bit("out_last", ifc.out_last, e.idx == LN - 1);
            if (tp_chk) begin
              if (e.idx == 0) check_vec("lane0_const", ifc.out_lane, 64'h0004_0000_0200_0001);
              check_int("lane_popcount", $countones(ifc.out_lane), (e.idx >= 14) ? 2 : 3);
            end
          end
        end
      end
      stall_prev = chk_en && !rst && ifc.out_valid && !ifc.out_ready;
      prev_lane  = ifc.out_lane;
      prev_idx   = int'(ifc.out_lane_index);
      prev_last  = ifc.out_last;
      done_now   = m_done;
      if (rst) begin
        m_fill = 1'b1; m_cnt = 0; m_lane = 0; m_err = 1'b0; m_done = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        chk_en = 1'b1;
      end else begin
        m_done = 1'b0;
        if (m_fill) begin
          if (ifc.in_valid) begin
            if (m_cnt == 0) begin
              m_t0 = cyc;
              if (done_now) b2b_hits++;
            end
            m_buf[m_cnt] = ifc.in_slice;
            if (ifc.in_last != (m_cnt == SL - 1)) m_err = 1'b1;
            m_cnt++;
            if (m_cnt == SL) begin
              for (int i = 0; i < LN; i++) begin
                e.idx = i;
                for (int z = 0; z < SL; z++) e.lane[z] = m_buf[z][i];
                exp_q.push_back(e);
              end
              m_cnt = 0; m_fill = 1'b0; m_lane = 0;
            end
          end
        end else if (ifc.out_ready) begin
          if (m_lane == LN - 1) begin
            m_done = 1'b1; m_fill = 1'b1; m_lane = 0;
            if (tp_chk) check_int("frame_cycles", cyc - m_t0 + 1, SL + LN);
          end else begin
            m_lane++;
          end
        end
      end
    end
  end

  // Consumer-side ready generator.
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = ~ifc.out_ready;
        2: ifc.out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Sends one frame from frame_data/frame_last; leaves in_valid high.
  task automatic send_frame(input bit gaps);
    int guard;
    for (int z = 0; z < SL; z++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          ifc.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      ifc.in_valid = 1'b1;
      ifc.in_slice = frame_data[z];
      ifc.in_last  = frame_last[z];
      guard = 0;
      forever begin
        @(negedge clk);
        if (ifc.in_ready) break;
        guard++;
        if (guard > 500) begin
          check_int("in_ready_timeout", guard, 0);
          break;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Waits until the model has seen the whole frame drained and done pulsed.
  task automatic wait_idle();
    int guard = 0;
    forever begin
      @(negedge clk);
      if (m_fill && m_cnt == 0 && exp_q.size() == 0) break;
      guard++;
      if (guard > 3000) begin
        check_int("drain_timeout", guard, 0);
        break;
      end
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic fill_frame(input int kind, input int bad_z);
    for (int z = 0; z < SL; z++) begin
      case (kind)
        0: frame_data[z] = 25'h1 << (z % LN);
        1: frame_data[z] = 25'h1FF_FFFF;
        default: frame_data[z] = 25'($urandom());
      endcase
      frame_last[z] = (bad_z >= 0) ? (z == bad_z) : (z == SL - 1);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_slice  = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_vec("reset_out_lane", ifc.out_lane, 64'h0);
    check_int("reset_index", int'(ifc.out_lane_index), 0);
    check_bit("reset_out_last", ifc.out_last, 1'b0);
    @(posedge clk); #1;

    // 1: walking-one frame, consumer always ready, minimum frame time
    out_mode = 0; tp_chk = 1'b1;
    fill_frame(0, -1);
    send_frame(1'b0);
    ifc.in_valid = 1'b0;
    wait_idle();
    tp_chk = 1'b0;

    // 2: all ones, ready toggling every cycle
    out_mode = 1;
    fill_frame(1, -1);
    send_frame(1'b0);
    ifc.in_valid = 1'b0;
    wait_idle();

    // 3: early in_last at z = 10
    out_mode = 0;
    fill_frame(2, 10);
    send_frame(1'b1);
    ifc.in_valid = 1'b0;
    wait_idle();
    check_bit("frame_err_sticky", ifc.frame_err, 1'b1);

    // 4: reset in the middle of the drain, then a clean frame
    out_mode = 3; ifc.out_ready = 1'b0;
    fill_frame(2, -1);
    send_frame(1'b0);
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    begin
      int guard = 0;
      forever begin
        @(negedge clk);
        if (ifc.out_valid && ifc.out_lane_index == 5'd6) break;
        guard++;
        if (guard > 200) begin
          check_int("lane6_timeout", guard, 0);
          break;
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; ifc.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("post_rst_out_valid", ifc.out_valid, 1'b0);
    check_bit("post_rst_in_ready", ifc.in_ready, 1'b1);
    check_bit("post_rst_frame_err", ifc.frame_err, 1'b0);
    check_int("post_rst_index", int'(ifc.out_lane_index), 0);
    @(posedge clk); #1;
    out_mode = 0;
    fill_frame(2, -1);
    send_frame(1'b0);
    ifc.in_valid = 1'b0;
    wait_idle();

    // 5: two frames back to back with in_valid held high
    b2b_hits = 0;
    out_mode = 0;
    fill_frame(2, -1);
    send_frame(1'b0);
    fill_frame(2, -1);
    send_frame(1'b0);
    ifc.in_valid = 1'b0;
    wait_idle();
    check_int("b2b_slice0_in_done_cycle", b2b_hits, 1);

    // 6: random data with random stalls on both sides
    out_mode = 2;
    for (int f = 0; f < 3; f++) begin
      fill_frame(2, -1);
      send_frame(1'b1);
      ifc.in_valid = 1'b0;
      wait_idle();
    end
    check_bit("random_frame_err", ifc.frame_err, 1'b0);
    check_int("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
